// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon Says game sequencer.
// Also holds the playback-speed helper used when SIMON_SPEEDUP_EN is defined.
package simon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COUNTDOWN,
        SHOW_ON,
        SHOW_OFF,
        WAIT_IN,
        GAME_OVER
    } state_t;

    localparam logic [1:0] CORR_NONE    = 2'b00;
    localparam logic [1:0] CORR_RIGHT   = 2'b01;
    localparam logic [1:0] CORR_WRONG   = 2'b10;
    localparam logic [1:0] CORR_TIMEOUT = 2'b11;

    // x^8 + x^6 + x^5 + x^4 + 1 as a mask over bits 7,5,4,3 of a shift-left register
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    // Halve a tick count once per completed group of four levels, never below one tick.
    function automatic logic [7:0] scale_tks(input logic [7:0] base, input logic [4:0] lvl);
        logic [7:0] s;
        s = base >> lvl[4:2];
        return (s == 8'd0) ? 8'd1 : s;
    endfunction

endpackage

// File: rtl/simon_lfsr.sv
// 8-bit Fibonacci LFSR producing one 2-bit colour element per step.
// load has priority over step so a round can restart from the captured seed.
module simon_lfsr
    import simon_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       step,
    input  logic [7:0] seed,
    output logic [1:0] value
);

    logic [7:0] lfsr_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_reg <= '0;
        end else if (load) begin
            lfsr_reg <= seed;
        end else if (step) begin
            lfsr_reg <= {lfsr_reg[6:0], ^(lfsr_reg & LFSR_TAPS)};
        end
    end

    assign value = lfsr_reg[1:0];

endmodule

// File: rtl/simon_game_ctrl.sv
// Simon Says round sequencer: countdown, LED playback, press checking, scoring pulses.
// Optional macro SIMON_SPEEDUP_EN shortens show/gap times as the level grows.
module simon_game_ctrl
    import simon_pkg::*;
#(
    parameter int         MAX_LEN       = 16,
    parameter int         COUNTDOWN_TKS = 3,
    parameter int         SHOW_TKS      = 2,
    parameter int         GAP_TKS       = 1,
    parameter int         TIMEOUT_TKS   = 8,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic [3:0] btn,
    output logic [3:0] led,
    output logic       start_disp,
    output logic [1:0] correct,
    output logic [4:0] level,
    output logic       win
);

    localparam logic [7:0] CD_TKS  = 8'(COUNTDOWN_TKS);
    localparam logic [7:0] SH_TKS  = 8'(SHOW_TKS);
    localparam logic [7:0] GP_TKS  = 8'(GAP_TKS);
    localparam logic [7:0] TO_TKS  = 8'(TIMEOUT_TKS);
    localparam logic [4:0] LEN_MAX = 5'(MAX_LEN);

    state_t     state_reg, state_next;
    logic [7:0] tmr_reg, tmr_next;
    logic [4:0] idx_reg, idx_next;
    logic [4:0] level_reg, level_next;
    logic [1:0] correct_reg, correct_next;
    logic       win_reg, win_next;
    logic [7:0] seed_reg, seed_next;
    logic [7:0] seed_cnt_reg;

    logic       lfsr_load, lfsr_step;
    logic [1:0] elem;
    logic [3:0] expected;
    logic [7:0] show_tks, gap_tks, wait_tks;
    logic       tmr_last, last_elem;

    simon_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .seed  (seed_reg),
        .value (elem)
    );

`ifdef SIMON_SPEEDUP_EN
    assign show_tks = scale_tks(SH_TKS, level_reg);
    assign gap_tks  = scale_tks(GP_TKS, level_reg);
`else
    assign show_tks = SH_TKS;
    assign gap_tks  = GP_TKS;
`endif

    always_comb begin
        case (state_reg)
            COUNTDOWN: wait_tks = CD_TKS;
            SHOW_ON:   wait_tks = show_tks;
            SHOW_OFF:  wait_tks = gap_tks;
            WAIT_IN:   wait_tks = TO_TKS;
            default:   wait_tks = 8'd1;
        endcase
    end

    // Only a tick can complete a wait; the timer itself counts completed ticks.
    assign tmr_last  = tick && (tmr_reg >= wait_tks - 8'd1);
    assign last_elem = (idx_reg + 5'd1) == level_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
            assign expected[gi] = (elem == 2'(gi));
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        tmr_next     = tmr_reg;
        idx_next     = idx_reg;
        level_next   = level_reg;
        correct_next = CORR_NONE;
        win_next     = win_reg;
        seed_next    = seed_reg;
        lfsr_load    = 1'b0;
        lfsr_step    = 1'b0;

        if (!start) begin
            state_next = IDLE;
            tmr_next   = '0;
            idx_next   = '0;
            level_next = 5'd1;
            win_next   = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = COUNTDOWN;
                    tmr_next   = '0;
                    idx_next   = '0;
                    level_next = 5'd1;
                    win_next   = 1'b0;
                    seed_next  = (seed_cnt_reg == 8'd0) ? LFSR_SEED : seed_cnt_reg;
                end
                COUNTDOWN: begin
                    if (tmr_last) begin
                        state_next = SHOW_ON;
                        tmr_next   = '0;
                        idx_next   = '0;
                        lfsr_load  = 1'b1;
                    end else if (tick) begin
                        tmr_next = tmr_reg + 8'd1;
                    end
                end
                SHOW_ON: begin
                    if (tmr_last) begin
                        state_next = SHOW_OFF;
                        tmr_next   = '0;
                    end else if (tick) begin
                        tmr_next = tmr_reg + 8'd1;
                    end
                end
                SHOW_OFF: begin
                    if (tmr_last) begin
                        tmr_next = '0;
                        if (!last_elem) begin
                            state_next = SHOW_ON;
                            idx_next   = idx_reg + 5'd1;
                            lfsr_step  = 1'b1;
                        end else begin
                            state_next = WAIT_IN;
                            idx_next   = '0;
                            lfsr_load  = 1'b1;
                        end
                    end else if (tick) begin
                        tmr_next = tmr_reg + 8'd1;
                    end
                end
                WAIT_IN: begin
                    // A press is evaluated before the timeout so it wins a same-cycle race.
                    if (btn == expected) begin
                        tmr_next = '0;
                        if (last_elem) begin
                            correct_next = CORR_RIGHT;
                            idx_next     = '0;
                            if (level_reg == LEN_MAX) begin
                                state_next = GAME_OVER;
                                win_next   = 1'b1;
                            end else begin
                                state_next = SHOW_ON;
                                level_next = level_reg + 5'd1;
                                lfsr_load  = 1'b1;
                            end
                        end else begin
                            idx_next  = idx_reg + 5'd1;
                            lfsr_step = 1'b1;
                        end
                    end else if (btn != 4'b0000) begin
                        correct_next = CORR_WRONG;
                        state_next   = GAME_OVER;
                    end else if (tmr_last) begin
                        correct_next = CORR_TIMEOUT;
                        state_next   = GAME_OVER;
                    end else if (tick) begin
                        tmr_next = tmr_reg + 8'd1;
                    end
                end
                GAME_OVER: begin
                    state_next = GAME_OVER;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            tmr_reg      <= '0;
            idx_reg      <= '0;
            level_reg    <= 5'd1;
            correct_reg  <= CORR_NONE;
            win_reg      <= 1'b0;
            seed_reg     <= '0;
            seed_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            tmr_reg      <= tmr_next;
            idx_reg      <= idx_next;
            level_reg    <= level_next;
            correct_reg  <= correct_next;
            win_reg      <= win_next;
            seed_reg     <= seed_next;
            seed_cnt_reg <= seed_cnt_reg + 8'd1;
        end
    end

    assign led        = (state_reg == SHOW_ON) ? expected : 4'b0000;
    assign start_disp = (state_reg != IDLE);
    assign correct    = correct_reg;
    assign level      = level_reg;
    assign win        = win_reg;

endmodule

// File: tb/tb_simon_game_ctrl.sv
// Directed bench for simon_game_ctrl (MAX_LEN=4, tick every cycle unless a test gates it).
// Seed 8'h01 gives the hand-derived LED order 0010, 0100, 0001, 0001.
module tb_simon_game_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       start;
    logic [3:0] btn;
    logic [3:0] led;
    logic       start_disp;
    logic [1:0] correct;
    logic [4:0] level;
    logic       win;

    int errors = 0;
    int checks = 0;

    logic [3:0] seq_led [4] = '{4'b0010, 4'b0100, 4'b0001, 4'b0001};

`ifdef SIMON_SPEEDUP_EN
    localparam int SPEEDUP = 1;
`else
    localparam int SPEEDUP = 0;
`endif

    always #5 clk = ~clk;

    simon_game_ctrl #(.MAX_LEN(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .start      (start),
        .btn        (btn),
        .led        (led),
        .start_disp (start_disp),
        .correct    (correct),
        .level      (level),
        .win        (win)
    );

    function automatic int exp_show(input int lvl);
        return (SPEEDUP != 0 && lvl >= 4) ? 1 : 2;
    endfunction

    // Reset, release, then raise start so the seed counter is captured at value 'target'.
    task automatic reset_start(input int target);
        reset = 1'b0; start = 1'b0; btn = 4'b0; tick = 1'b1;
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        repeat (target) @(negedge clk);
        start = 1'b1;
    endtask

    task automatic press(input logic [3:0] b);
        btn = b;
        @(negedge clk);
        btn = 4'b0;
    endtask

    // Waits (bounded) for a lit LED, returns its value and how many cycles it stayed lit.
    task automatic watch_element(output logic [3:0] seen, output int lit);
        int n;
        n = 0;
        while (led == 4'b0 && n < 40) begin @(negedge clk); n++; end
        seen = led;
        lit  = 0;
        while (led != 4'b0 && lit < 40) begin lit++; @(negedge clk); end
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b1; tick = 1'b1; btn = 4'b0;
        repeat (3) @(negedge clk);
        checks++; if (led !== 4'b0)        begin errors++; $display("FAIL reset_led: got %b want 0000", led); end
        checks++; if (start_disp !== 1'b0) begin errors++; $display("FAIL reset_start_disp: got %b want 0", start_disp); end
        checks++; if (correct !== 2'b00)   begin errors++; $display("FAIL reset_correct: got %b want 00", correct); end
        checks++; if (level !== 5'd1)      begin errors++; $display("FAIL reset_level: got %0d want 1", level); end
        checks++; if (win !== 1'b0)        begin errors++; $display("FAIL reset_win: got %b want 0", win); end
        $display("reset: led=%b start_disp=%b correct=%b level=%0d win=%b", led, start_disp, correct, level, win);
    endtask

    task automatic test_tick_gating;
        int n;
        reset_start(1);
        tick = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (start_disp !== 1'b1) begin errors++; $display("FAIL gate_start_disp: got %b want 1", start_disp); end
        checks++; if (led !== 4'b0)        begin errors++; $display("FAIL gate_led_held: got %b want 0000", led); end
        tick = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (led == 4'b0 && n < 20);
        checks++; if (n !== 3) begin errors++; $display("FAIL gate_countdown: got %0d want 3 ticks", n); end
        $display("tick_gating: countdown ticks=%0d", n);
    endtask

    task automatic test_show;
        logic [3:0] seen;
        int n, lit;
        reset_start(1);
        @(negedge clk);
        checks++; if (start_disp !== 1'b1) begin errors++; $display("FAIL show_start_disp: got %b want 1", start_disp); end
        checks++; if (led !== 4'b0)        begin errors++; $display("FAIL show_led_countdown: got %b want 0000", led); end
        n = 0;
        do begin @(negedge clk); n++; end while (led == 4'b0 && n < 20);
        checks++; if (n !== 3) begin errors++; $display("FAIL show_countdown: got %0d want 3", n); end
        watch_element(seen, lit);
        checks++; if (seen !== 4'b0010) begin errors++; $display("FAIL show_first_led: got %b want 0010", seen); end
        checks++; if (lit !== 2)        begin errors++; $display("FAIL show_lit_len: got %0d want 2", lit); end
        $display("show: seed=01 countdown=%0d led=%b lit=%0d", n, seen, lit);
    endtask

    task automatic test_seed_zero;
        logic [3:0] seen;
        int lit;
        reset_start(0);
        watch_element(seen, lit);
        checks++; if (seen !== 4'b0010) begin errors++; $display("FAIL seed_zero_led: got %b want 0010", seen); end
        $display("seed_zero: led=%b", seen);
    endtask

    task automatic test_round_right;
        logic [3:0] seen;
        int lit;
        reset_start(1);
        watch_element(seen, lit);
        @(negedge clk);
        press(4'b0010);
        checks++; if (correct !== 2'b01) begin errors++; $display("FAIL right_code: got %b want 01", correct); end
        checks++; if (level !== 5'd2)    begin errors++; $display("FAIL right_level: got %0d want 2", level); end
        checks++; if (led !== 4'b0010)   begin errors++; $display("FAIL right_replay0: got %b want 0010", led); end
        @(negedge clk);
        checks++; if (correct !== 2'b00) begin errors++; $display("FAIL right_pulse_width: got %b want 00", correct); end
        checks++; if (led !== 4'b0010)   begin errors++; $display("FAIL right_replay0_hold: got %b want 0010", led); end
        @(negedge clk);
        checks++; if (led !== 4'b0000)   begin errors++; $display("FAIL right_gap: got %b want 0000", led); end
        watch_element(seen, lit);
        checks++; if (seen !== 4'b0100)  begin errors++; $display("FAIL right_replay1: got %b want 0100", seen); end
        checks++; if (lit !== 2)         begin errors++; $display("FAIL right_replay1_len: got %0d want 2", lit); end
        $display("round_right: level=%0d second led=%b lit=%0d", level, seen, lit);
    endtask

    task automatic test_wrong;
        logic [3:0] seen;
        int lit;
        reset_start(1);
        watch_element(seen, lit);
        @(negedge clk);
        press(4'b0011);
        checks++; if (correct !== 2'b10) begin errors++; $display("FAIL wrong_code: got %b want 10", correct); end
        checks++; if (led !== 4'b0)      begin errors++; $display("FAIL wrong_led: got %b want 0000", led); end
        @(negedge clk);
        checks++; if (correct !== 2'b00)   begin errors++; $display("FAIL wrong_pulse_width: got %b want 00", correct); end
        checks++; if (start_disp !== 1'b1) begin errors++; $display("FAIL wrong_disp_hold: got %b want 1", start_disp); end
        press(4'b0010);
        checks++; if (correct !== 2'b00)   begin errors++; $display("FAIL over_btn_ignored: got %b want 00", correct); end
        start = 1'b0;
        @(negedge clk);
        checks++; if (start_disp !== 1'b0) begin errors++; $display("FAIL stop_disp: got %b want 0", start_disp); end
        checks++; if (level !== 5'd1)      begin errors++; $display("FAIL stop_level: got %0d want 1", level); end
        checks++; if (correct !== 2'b00)   begin errors++; $display("FAIL stop_correct: got %b want 00", correct); end
        $display("wrong: multi-hot press -> game over, start low -> idle");
    endtask

    task automatic test_timeout;
        logic [3:0] seen;
        int lit;
        reset_start(1);
        @(negedge clk);
        press(4'b1000);
        checks++; if (correct !== 2'b00) begin errors++; $display("FAIL countdown_btn_ignored: got %b want 00", correct); end
        watch_element(seen, lit);
        checks++; if (seen !== 4'b0010)  begin errors++; $display("FAIL timeout_led: got %b want 0010", seen); end
        @(negedge clk);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            checks++; if (correct !== 2'b00) begin errors++; $display("FAIL timeout_early t=%0d: got %b want 00", i, correct); end
        end
        @(negedge clk);
        checks++; if (correct !== 2'b11)   begin errors++; $display("FAIL timeout_code: got %b want 11", correct); end
        checks++; if (start_disp !== 1'b1) begin errors++; $display("FAIL timeout_disp: got %b want 1", start_disp); end
        $display("timeout: correct=%b after 8 idle ticks", correct);

        reset_start(1);
        watch_element(seen, lit);
        @(negedge clk);
        repeat (7) @(negedge clk);
        press(4'b0010);
        checks++; if (correct !== 2'b01) begin errors++; $display("FAIL press_on_timeout_code: got %b want 01", correct); end
        checks++; if (level !== 5'd2)    begin errors++; $display("FAIL press_on_timeout_level: got %0d want 2", level); end
        $display("press_wins: correct=%b level=%0d", correct, level);
    endtask

    task automatic test_win;
        logic [3:0] seen;
        int lit;
        reset_start(1);
        for (int lv = 1; lv <= 4; lv++) begin
            for (int i = 0; i < lv; i++) begin
                watch_element(seen, lit);
                checks++; if (seen !== seq_led[i])   begin errors++; $display("FAIL win_l%0d_e%0d_led: got %b want %b", lv, i, seen, seq_led[i]); end
                checks++; if (lit !== exp_show(lv)) begin errors++; $display("FAIL win_l%0d_e%0d_len: got %0d want %0d", lv, i, lit, exp_show(lv)); end
            end
            @(negedge clk);
            for (int i = 0; i < lv - 1; i++) begin
                press(seq_led[i]);
                checks++; if (correct !== 2'b00) begin errors++; $display("FAIL win_l%0d_mid%0d: got %b want 00", lv, i, correct); end
            end
            press(seq_led[lv-1]);
            checks++; if (correct !== 2'b01) begin errors++; $display("FAIL win_l%0d_code: got %b want 01", lv, correct); end
            $display("win: level %0d cleared, correct=%b level=%0d win=%b", lv, correct, level, win);
        end
        checks++; if (win !== 1'b1)        begin errors++; $display("FAIL win_flag: got %b want 1", win); end
        checks++; if (level !== 5'd4)      begin errors++; $display("FAIL win_level: got %0d want 4", level); end
        checks++; if (led !== 4'b0)        begin errors++; $display("FAIL win_led: got %b want 0000", led); end
        checks++; if (start_disp !== 1'b1) begin errors++; $display("FAIL win_disp: got %b want 1", start_disp); end
        start = 1'b0;
        @(negedge clk);
        checks++; if (win !== 1'b0)        begin errors++; $display("FAIL win_clear: got %b want 0", win); end
    endtask

    task automatic test_async_reset;
        logic [3:0] seen;
        int lit;
        reset_start(1);
        watch_element(seen, lit);
        @(negedge clk);
        press(4'b0010);
        reset = 1'b0;
        #1;
        checks++; if (led !== 4'b0)        begin errors++; $display("FAIL areset_led: got %b want 0000", led); end
        checks++; if (correct !== 2'b00)   begin errors++; $display("FAIL areset_correct: got %b want 00", correct); end
        checks++; if (level !== 5'd1)      begin errors++; $display("FAIL areset_level: got %0d want 1", level); end
        checks++; if (start_disp !== 1'b0) begin errors++; $display("FAIL areset_idle: got %b want 0", start_disp); end
        $display("async_reset: led=%b correct=%b level=%0d start_disp=%b", led, correct, level, start_disp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_tick_gating();
        test_show();
        test_seed_zero();
        test_round_right();
        test_wrong();
        test_timeout();
        test_win();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
